// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display that shares one registered BCD-to-7-segment
// decoder across all digits.
//
// Each digit slot is GUARD_CYCLES of blanking (all enables high) followed by
// REFRESH_DIV cycles of drive (one enable low). The decoder inputs switch at
// the start of the blank phase, so the registered decoder output has settled
// before the digit is enabled. New data is staged in a shadow register and
// only becomes active at a frame wrap, so a frame never mixes old and new digits.
//
// Optional build macro:
//   SEG_LEAD_ZERO_BLANK_EN -- when defined, leading zero digits (i>0, this and
//   all higher digits zero, no error) keep their enable high during DRIVE.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   digits_in      in   4*NUM_DIGITS BCD digits, digit i at [4i+3:4i]
//   load           in   one-cycle strobe capturing digits_in/err_in into the shadow
//   err_in         in   error flag captured with load
//   bcd_out        out  BCD value for the shared decoder
//   dec_err        out  error-glyph select for the shared decoder
//   digit_en_n     out  active-low per-digit enables (one-hot-low or all high)
//   digit_idx      out  index of the current digit slot
//   update_pending out  shadow holds data not yet applied
//   frame_done     out  one-cycle pulse on the first blank cycle of digit 0
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic                          err_in,
  output logic [3:0]                    bcd_out,
  output logic                          dec_err,
  output logic [NUM_DIGITS-1:0]         digit_en_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          update_pending,
  output logic                          frame_done
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CW   = ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic                    state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    aerr_q, aerr_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    serr_q, serr_d;
  logic                    pend_q, pend_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    dec_err_q, dec_err_d;
  logic [NUM_DIGITS-1:0]   en_n_q, en_n_d;
  logic                    frame_done_q, frame_done_d;
  logic                    wrap_s;
  logic                    sup_s;
  logic [3:0]              cur_digit_s;

`ifdef SEG_LEAD_ZERO_BLANK_EN
  // A slot is a leading zero when it is not digit 0, no error is shown, and
  // this digit and every higher digit are zero.
  function automatic logic lead_zero(input logic [4*NUM_DIGITS-1:0] d,
                                     input logic [IW-1:0] idx,
                                     input logic err);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (d[4*i +: 4] != 4'd0)) begin
        all_zero = 1'b0;
      end else begin
        all_zero = all_zero;
      end
    end
    return all_zero && (idx != '0) && !err;
  endfunction
`endif

  // Scan sequencer, shadow capture and frame-boundary data transfer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    active_d = active_q;
    aerr_d   = aerr_q;
    shadow_d = shadow_q;
    serr_d   = serr_q;
    pend_d   = pend_q;
    wrap_s   = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            wrap_s = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    if (load) begin
      shadow_d = digits_in;
      serr_d   = err_in;
    end else begin
      shadow_d = shadow_q;
      serr_d   = serr_q;
    end

    // A load coinciding with the wrap bypasses the shadow so the new frame
    // shows it immediately and nothing is left pending.
    if (wrap_s) begin
      if (load) begin
        active_d = digits_in;
        aerr_d   = err_in;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        active_d = shadow_q;
        aerr_d   = serr_q;
        pend_d   = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Output decode from next-state values so the registered outputs line up
  // with the state they describe.
  always_comb begin
    cur_digit_s  = active_d[{idx_d, 2'b00} +: 4];
    bcd_d        = cur_digit_s;
    dec_err_d    = aerr_d | (cur_digit_s > 4'd9);
    frame_done_d = wrap_s;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    sup_s = lead_zero(active_d, idx_d, aerr_d);
`else
    sup_s = 1'b0;
`endif
    en_n_d = '1;
    if ((state_d == ST_DRIVE) && !sup_s) begin
      en_n_d[idx_d] = 1'b0;
    end else begin
      en_n_d = '1;
    end
  end

  // State, data and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      aerr_q       <= 1'b0;
      shadow_q     <= '0;
      serr_q       <= 1'b0;
      pend_q       <= 1'b0;
      bcd_q        <= 4'd0;
      dec_err_q    <= 1'b0;
      en_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      aerr_q       <= aerr_d;
      shadow_q     <= shadow_d;
      serr_q       <= serr_d;
      pend_q       <= pend_d;
      bcd_q        <= bcd_d;
      dec_err_q    <= dec_err_d;
      en_n_q       <= en_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd_out        = bcd_q;
  assign dec_err        = dec_err_q;
  assign digit_en_n     = en_n_q;
  assign digit_idx      = idx_q;
  assign update_pending = pend_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl with NUM_DIGITS=4,
// REFRESH_DIV=4, GUARD_CYCLES=2 (slot = 6 cycles, frame = 24 cycles).
// Cycle 0 is the first cycle after rst_n is released.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        load = 1'b0;
  logic        err_in = 1'b0;
  logic [3:0]  bcd_out;
  logic        dec_err;
  logic [3:0]  digit_en_n;
  logic [1:0]  digit_idx;
  logic        update_pending;
  logic        frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
    .err_in(err_in), .bcd_out(bcd_out), .dec_err(dec_err),
    .digit_en_n(digit_en_n), .digit_idx(digit_idx),
    .update_pending(update_pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] din;
    logic        ein;
    logic [3:0]  en;
    logic [3:0]  bcd;
    logic        err;
    logic [1:0]  idx;
    logic        fd;
    logic        pend;
  } vec_t;

  vec_t vecs[$];
  int   cyc;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic vec_t mk(int c, logic ld, logic [15:0] din, logic ein,
                              logic [3:0] en, logic [3:0] bcd, logic err,
                              logic [1:0] idx, logic fd, logic pend);
    vec_t v;
    v.cyc = c; v.ld = ld; v.din = din; v.ein = ein;
    v.en = en; v.bcd = bcd; v.err = err; v.idx = idx; v.fd = fd; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] en, input logic [3:0] bcd,
                     input logic err, input logic [1:0] idx, input logic fd,
                     input logic pend);
    n_checks++;
    if (digit_en_n === en && bcd_out === bcd && dec_err === err &&
        digit_idx === idx && frame_done === fd && update_pending === pend) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d got en=%b bcd=%h err=%b idx=%0d fd=%b pend=%b want en=%b bcd=%h err=%b idx=%0d fd=%b pend=%b",
               name, cyc, digit_en_n, bcd_out, dec_err, digit_idx, frame_done,
               update_pending, en, bcd, err, idx, fd, pend);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    load = 1'b0;
  endtask

  initial begin
`ifdef SEG_LEAD_ZERO_BLANK_EN
    vecs.push_back(mk(0,   1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(2,   1'b1, 16'h0050, 1'b0, 4'hE, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(3,   1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(24,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(26,  1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(32,  1'b0, 16'h0000, 1'b0, 4'hD, 4'h5, 1'b0, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(38,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0));
    vecs.push_back(mk(44,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0));
`else
    // frame 0: all-zero data, basic scan timing
    vecs.push_back(mk(0,   1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1,   1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(2,   1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(5,   1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(6,   1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(8,   1'b0, 16'h0000, 1'b0, 4'hD, 4'h0, 1'b0, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(18,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0));
    vecs.push_back(mk(20,  1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0));
    vecs.push_back(mk(23,  1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0));
    vecs.push_back(mk(24,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(25,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    // frame 1: mid-frame load of 4321 stays pending
    vecs.push_back(mk(26,  1'b1, 16'h4321, 1'b0, 4'hE, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(27,  1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(32,  1'b0, 16'h0000, 1'b0, 4'hD, 4'h0, 1'b0, 2'd1, 1'b0, 1'b1));
    vecs.push_back(mk(47,  1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b0, 2'd3, 1'b0, 1'b1));
    // frame 2: 4321 active; load 4A21
    vecs.push_back(mk(48,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h1, 1'b0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(50,  1'b1, 16'h4A21, 1'b0, 4'hE, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(51,  1'b0, 16'h0000, 1'b0, 4'hE, 4'h1, 1'b0, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(56,  1'b0, 16'h0000, 1'b0, 4'hD, 4'h2, 1'b0, 2'd1, 1'b0, 1'b1));
    vecs.push_back(mk(62,  1'b0, 16'h0000, 1'b0, 4'hB, 4'h3, 1'b0, 2'd2, 1'b0, 1'b1));
    vecs.push_back(mk(68,  1'b0, 16'h0000, 1'b0, 4'h7, 4'h4, 1'b0, 2'd3, 1'b0, 1'b1));
    vecs.push_back(mk(71,  1'b0, 16'h0000, 1'b0, 4'h7, 4'h4, 1'b0, 2'd3, 1'b0, 1'b1));
    // frame 3: 4A21 active (invalid digit 2); load 4321 with err
    vecs.push_back(mk(72,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h1, 1'b0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(74,  1'b0, 16'h0000, 1'b0, 4'hE, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(75,  1'b1, 16'h4321, 1'b1, 4'hE, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(80,  1'b0, 16'h0000, 1'b0, 4'hD, 4'h2, 1'b0, 2'd1, 1'b0, 1'b1));
    vecs.push_back(mk(84,  1'b0, 16'h0000, 1'b0, 4'hF, 4'hA, 1'b1, 2'd2, 1'b0, 1'b1));
    vecs.push_back(mk(86,  1'b0, 16'h0000, 1'b0, 4'hB, 4'hA, 1'b1, 2'd2, 1'b0, 1'b1));
    vecs.push_back(mk(92,  1'b0, 16'h0000, 1'b0, 4'h7, 4'h4, 1'b0, 2'd3, 1'b0, 1'b1));
    // frame 4: error flag active in every slot; load 9876 on the wrap edge
    vecs.push_back(mk(96,  1'b0, 16'h0000, 1'b0, 4'hF, 4'h1, 1'b1, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(98,  1'b0, 16'h0000, 1'b0, 4'hE, 4'h1, 1'b1, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(110, 1'b0, 16'h0000, 1'b0, 4'hB, 4'h3, 1'b1, 2'd2, 1'b0, 1'b0));
    vecs.push_back(mk(116, 1'b0, 16'h0000, 1'b0, 4'h7, 4'h4, 1'b1, 2'd3, 1'b0, 1'b0));
    vecs.push_back(mk(119, 1'b1, 16'h9876, 1'b0, 4'h7, 4'h4, 1'b1, 2'd3, 1'b0, 1'b0));
    // frame 5: 9876 applied directly, nothing pending
    vecs.push_back(mk(120, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h6, 1'b0, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(121, 1'b0, 16'h0000, 1'b0, 4'hF, 4'h6, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(122, 1'b0, 16'h0000, 1'b0, 4'hE, 4'h6, 1'b0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(128, 1'b0, 16'h0000, 1'b0, 4'hD, 4'h7, 1'b0, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(134, 1'b0, 16'h0000, 1'b0, 4'hB, 4'h8, 1'b0, 2'd2, 1'b0, 1'b0));
`endif

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    foreach (vecs[k]) begin
      while (cyc < vecs[k].cyc) step();
      chk("vec", vecs[k].en, vecs[k].bcd, vecs[k].err, vecs[k].idx,
          vecs[k].fd, vecs[k].pend);
      if (vecs[k].ld) begin
        load      = 1'b1;
        digits_in = vecs[k].din;
        err_in    = vecs[k].ein;
      end
    end

`ifndef SEG_LEAD_ZERO_BLANK_EN
    // Asynchronous reset during the DRIVE phase of digit 2.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    chk("restart_c0", 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    chk("restart_c1", 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    chk("restart_c2", 4'hE, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
